// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART word path: serializer FSM
//                state encoding, the error-marker word agreed between sender
//                and receiver, the byte order, and byte-selection helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Serializer FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_STROBE = 3'd1;
    localparam logic [2:0] c_ST_ACK    = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_GAP    = 3'd4;

    // Error-marker pattern recognised by both ends of the link
    localparam logic [15:0] ERROR_WORD = 16'hCCCC;

    // The far-end assembler places the first received byte in bits 7:0
    localparam logic LOW_FIRST = 1'b1;

    function automatic logic [7:0] first_byte(input logic [15:0] word);
        return LOW_FIRST ? word[7:0] : word[15:8];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] word);
        return LOW_FIRST ? word[15:8] : word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_down_counter
//  Description : Loadable down counter that saturates at zero.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset (count -> 0)
//                i_load     - load i_load_val (has priority over i_en)
//                i_load_val - value to load
//                i_en       - decrement by one while nonzero
//                o_zero     - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_serializer
//  Description : Splits a 16-bit word into two bytes (low byte first) and
//                hands them to a UART transmitter over a tx_wr / tx_busy
//                handshake, followed by an enforced idle gap.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                word_in      - word to send, taken when word_valid && word_ready
//                word_valid   - upstream has a word
//                word_ready   - block is idle and will accept a word
//                tx_data      - byte to the transmitter
//                tx_wr        - one-cycle write strobe
//                tx_busy      - transmitter is shifting a byte
//                timeout_err  - sticky: busy never acknowledged a strobe
//                sending      - a word is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_serializer
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic        timeout_err,
    output logic        sending
);

    localparam int c_ACK_W = $clog2((ACK_TIMEOUT > 2) ? ACK_TIMEOUT : 2);
    localparam int c_GAP_W = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);

    // The ack counter is loaded in STROBE and counts down during ACK; the
    // timeout fires in the ACK cycle where it has reached zero, so the error
    // flag becomes visible ACK_TIMEOUT cycles after the tx_wr cycle.
    localparam logic [c_ACK_W-1:0] c_ACK_LOAD =
        c_ACK_W'((ACK_TIMEOUT >= 2) ? ACK_TIMEOUT - 2 : 0);

    // GAP lasts GAP_CYCLES cycles: loaded with GAP_CYCLES-1 on entry and
    // left when the count is zero.
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD =
        c_GAP_W'((GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0);

    // With no gap configured the word ends straight into IDLE.
    localparam logic [2:0] c_AFTER_WORD = (GAP_CYCLES == 0) ? c_ST_IDLE : c_ST_GAP;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_hold;
    logic        r_byte_sel;
    logic [7:0]  r_tx_data;
    logic        r_timeout_err;

    logic        w_accept;
    logic        w_ack_load;
    logic        w_ack_en;
    logic        w_ack_zero;
    logic        w_gap_load;
    logic        w_gap_en;
    logic        w_gap_zero;
    logic        w_timeout;
    logic        w_next_byte;

    assign w_accept    = (r_state == c_ST_IDLE) && word_valid;
    assign w_ack_en    = (r_state == c_ST_ACK);
    assign w_gap_en    = (r_state == c_ST_GAP);
    assign w_timeout   = (r_state == c_ST_ACK) && !tx_busy && w_ack_zero;
    assign w_next_byte = (r_state == c_ST_DRAIN) && !tx_busy && !r_byte_sel;

    always_comb begin
        w_next_state = r_state;
        w_ack_load   = 1'b0;
        w_gap_load   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (word_valid) begin
                    w_next_state = c_ST_STROBE;
                end
            end
            c_ST_STROBE: begin
                w_next_state = c_ST_ACK;
                w_ack_load   = 1'b1;
            end
            c_ST_ACK: begin
                if (tx_busy) begin
                    w_next_state = c_ST_DRAIN;
                end else if (w_ack_zero) begin
                    // Abandon the rest of the word
                    w_next_state = c_AFTER_WORD;
                    w_gap_load   = 1'b1;
                end
            end
            c_ST_DRAIN: begin
                if (!tx_busy) begin
                    if (!r_byte_sel) begin
                        w_next_state = c_ST_STROBE;
                    end else begin
                        w_next_state = c_AFTER_WORD;
                        w_gap_load   = 1'b1;
                    end
                end
            end
            c_ST_GAP: begin
                if (w_gap_zero) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_hold        <= '0;
            r_byte_sel    <= 1'b0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_hold     <= word_in;
                r_byte_sel <= 1'b0;
                r_tx_data  <= first_byte(word_in);
            end
            // tx_data only changes on these two events, which keeps it
            // stable from STROBE through the end of DRAIN.
            if (w_next_byte) begin
                r_byte_sel <= 1'b1;
                r_tx_data  <= second_byte(r_hold);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    uart_down_counter #(
        .WIDTH (c_ACK_W)
    ) u_ack_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_ack_load),
        .i_load_val (c_ACK_LOAD),
        .i_en       (w_ack_en),
        .o_zero     (w_ack_zero)
    );

    uart_down_counter #(
        .WIDTH (c_GAP_W)
    ) u_gap_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_gap_load),
        .i_load_val (c_GAP_LOAD),
        .i_en       (w_gap_en),
        .o_zero     (w_gap_zero)
    );

    assign word_ready  = (r_state == c_ST_IDLE);
    assign tx_wr       = (r_state == c_ST_STROBE);
    assign sending     = (r_state == c_ST_STROBE) || (r_state == c_ST_ACK) ||
                         (r_state == c_ST_DRAIN);
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_serializer
//  Description : Scoreboard bench for uart_word_serializer. Stimulus pushes
//                the expected byte stream into a queue; monitors pop and
//                compare on every tx_wr strobe. A second instance with
//                GAP_CYCLES=0 and a same-cycle busy transmitter covers the
//                zero-gap corner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_serializer;
    import uart_pkg::*;

    localparam int GAP_CYCLES  = 16;
    localparam int ACK_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        timeout_err;
    logic        sending;

    logic [15:0] word_in0;
    logic        word_valid0;
    logic        word_ready0;
    logic [7:0]  tx_data0;
    logic        tx_wr0;
    logic        tx_busy0;
    logic        timeout_err0;
    logic        sending0;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp0_q[$];
    logic [7:0]  last_tx  = 8'h00;
    logic        xmit_en;
    logic [4:0]  bcnt     = 5'd0;
    logic [4:0]  bcnt0    = 5'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_serializer #(
        .GAP_CYCLES  (GAP_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err),
        .sending     (sending)
    );

    uart_word_serializer #(
        .GAP_CYCLES  (0),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in0),
        .word_valid  (word_valid0),
        .word_ready  (word_ready0),
        .tx_data     (tx_data0),
        .tx_wr       (tx_wr0),
        .tx_busy     (tx_busy0),
        .timeout_err (timeout_err0),
        .sending     (sending0)
    );

    // Transmitter model: busy rises the cycle after tx_wr, held 10 cycles.
    always @(posedge clk) begin
        if (tx_wr && xmit_en) bcnt <= 5'd10;
        else if (bcnt != 5'd0) bcnt <= bcnt - 5'd1;
    end
    assign tx_busy = (bcnt != 5'd0);

    // Transmitter model for dut0: busy already high in the strobe cycle.
    always @(posedge clk) begin
        if (tx_wr0) bcnt0 <= 5'd9;
        else if (bcnt0 != 5'd0) bcnt0 <= bcnt0 - 5'd1;
    end
    assign tx_busy0 = tx_wr0 || (bcnt0 != 5'd0);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every strobe must match the next expected byte; tx_data must
    // hold its strobed value for the rest of the byte.
    always @(negedge clk) begin
        if (tx_wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got tx_data 0x%0h, expected no strobe (cycle %0d)", tx_data, cyc);
            end else begin
                chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
            last_tx = tx_data;
        end else if (sending) begin
            chk("tx_data_stable", int'(tx_data), int'(last_tx));
        end
    end

    always @(negedge clk) begin
        if (tx_wr0) begin
            if (exp0_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe0: got tx_data 0x%0h, expected no strobe (cycle %0d)", tx_data0, cyc);
            end else begin
                chk("tx_byte0", int'(tx_data0), int'(exp0_q.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int i;
        for (i = 0; i < 500 && !word_ready; i++) @(negedge clk);
        if (!word_ready) chk("wait_ready_timeout", 0, 1);
    endtask

    // Returns at the negedge of the STROBE cycle of the accepted word.
    task automatic start_word(input logic [15:0] w);
        wait_ready();
        word_in    = w;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        chk("accept_latency_tx_wr", int'(tx_wr), 1);
    endtask

    // Follows a word from its first strobe until word_ready returns.
    // fall_c: first cycle busy is low after the last byte; rise_c: ready.
    task automatic wait_done(input int exp_wr, output int fall_c, output int rise_c);
        int  nwr;
        bit  seen;
        bit  gap_wr;
        nwr = 0; seen = 0; gap_wr = 0; fall_c = -1; rise_c = -1;
        for (int i = 0; i < 400; i++) begin
            if (tx_wr) begin
                nwr++;
                if (fall_c >= 0) gap_wr = 1;
            end
            if (nwr == exp_wr && tx_busy) seen = 1;
            if (seen && !tx_busy && fall_c < 0) fall_c = cyc;
            if (word_ready && fall_c >= 0) begin
                rise_c = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("no_strobe_in_gap", int'(gap_wr), 0);
        chk("strobe_count", nwr, exp_wr);
        if (rise_c < 0) chk("word_done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, r, s, t, s2, nwr;
        reset = 1'b1; word_in = '0; word_valid = 1'b0; xmit_en = 1'b1;
        word_in0 = '0; word_valid0 = 1'b0;

        // ---- Reset state
        repeat (3) @(negedge clk);
        chk("rst_word_ready", int'(word_ready), 1);
        chk("rst_tx_wr", int'(tx_wr), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_sending", int'(sending), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // ---- 1: single word, low byte first. Per-word total is
        // 1 + 2*(1+1+10) + GAP_CYCLES, so ready returns GAP_CYCLES+1 cycles
        // after the first cycle busy is seen low for the high byte.
        exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
        start_word(16'hA55A);
        chk("t1_sending", int'(sending), 1);
        wait_done(2, f, r);
        chk("t1_gap_len", r - f, GAP_CYCLES + 1);
        chk("t1_timeout_err", int'(timeout_err), 0);

        // ---- 2: back-to-back with word_valid held high
        wait_ready();
        word_in = 16'h1234; word_valid = 1'b1;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        @(negedge clk);
        word_in = ERROR_WORD;
        exp_q.push_back(8'hCC); exp_q.push_back(8'hCC);
        wait_done(2, f, r);
        chk("t2_gap_len_w1", r - f, GAP_CYCLES + 1);
        @(negedge clk);
        chk("t2_accept_after_gap", int'(tx_wr), 1);
        word_valid = 1'b0;
        wait_done(2, f, r);
        chk("t2_gap_len_w2", r - f, GAP_CYCLES + 1);

        // ---- 3: busy never rises -> timeout, high byte dropped
        xmit_en = 1'b0;
        exp_q.push_back(8'h34);
        start_word(16'h1234);
        s = cyc; t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (timeout_err) begin t = cyc; break; end
        end
        chk("t3_timeout_delay", t - s, ACK_TIMEOUT);
        chk("t3_sending_low", int'(sending), 0);
        r = -1;
        for (int i = 0; i < 200; i++) begin
            if (word_ready) begin r = cyc; break; end
            @(negedge clk);
        end
        chk("t3_gap_after_timeout", r - t, GAP_CYCLES);
        xmit_en = 1'b1;
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        start_word(16'h5678);
        wait_done(2, f, r);
        chk("t3_timeout_sticky", int'(timeout_err), 1);

        // ---- 4: reset during DRAIN of the low byte (with word_valid high)
        exp_q.push_back(8'hEF);
        start_word(16'hBEEF);
        repeat (3) @(negedge clk);
        chk("t4_midword", int'(sending), 1);
        reset = 1'b1; word_valid = 1'b1; word_in = 16'h1111;
        @(negedge clk);
        chk("t4_word_ready", int'(word_ready), 1);
        chk("t4_tx_wr", int'(tx_wr), 0);
        chk("t4_sending", int'(sending), 0);
        chk("t4_tx_data", int'(tx_data), 0);
        chk("t4_timeout_err", int'(timeout_err), 0);
        reset = 1'b0; word_valid = 1'b0;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hC0);
        start_word(16'hC0DE);
        wait_done(2, f, r);

        // ---- 6: word_valid / word_in wiggled while sending
        exp_q.push_back(8'h3C); exp_q.push_back(8'h9A);
        start_word(16'h9A3C);
        for (int i = 0; i < 60; i++) begin
            if (!sending) break;
            word_valid = ~word_valid;
            word_in    = 16'($urandom);
            @(negedge clk);
        end
        word_valid = 1'b0;
        wait_ready();

        // ---- 5: GAP_CYCLES=0, busy high in the strobe cycle
        exp0_q.push_back(8'h0D); exp0_q.push_back(8'hF0);
        chk("t5_ready0", int'(word_ready0), 1);
        word_in0 = 16'hF00D; word_valid0 = 1'b1;
        @(negedge clk);
        word_valid0 = 1'b0;
        chk("t5_tx_wr0", int'(tx_wr0), 1);
        s = cyc; s2 = -1; f = -1; r = -1; nwr = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_wr0) begin nwr++; s2 = cyc; end
            if (s2 >= 0 && cyc > s2 && !tx_busy0 && f < 0) f = cyc;
            if (f >= 0 && word_ready0) begin r = cyc; break; end
        end
        chk("t5_strobes0", nwr, 2);
        chk("t5_strobe_spacing", s2 - s, 11);
        chk("t5_ready_after_fall", r - f, 1);
        chk("t5_timeout_err0", int'(timeout_err0), 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("sb0_empty", exp0_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
